// File: rtl/ghost_collision_ctrl.sv
// ============================================================================
// ghost_collision_ctrl : player/ghost contact detection, lives, death freeze,
// respawn and game-over. Optional FRIGHT_EN adds frightened-ghost eating.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ghost_collision_ctrl #(
   parameter int NUM_GHOSTS  = 4,
   parameter int LIVES_INIT  = 3,
   parameter int DEATH_TICKS = 8
) (
   input  logic                                                   clk,
   input  logic                                                   reset,
   input  logic                                                   move_tick,
   input  logic [9:0]                                             player_x,
   input  logic [8:0]                                             player_y,
   input  logic [NUM_GHOSTS*10-1:0]                               ghost_x,
   input  logic [NUM_GHOSTS*9-1:0]                                ghost_y,
`ifdef FRIGHT_EN
   input  logic [NUM_GHOSTS-1:0]                                  ghost_fright,
   output logic                                                   ghost_eaten,
   output logic [((NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1)-1:0] eaten_ghost,
`endif
   output logic                                                   hit,
   output logic [((NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1)-1:0] hit_ghost,
   output logic [2:0]                                             lives,
   output logic                                                   freeze,
   output logic                                                   respawn,
   output logic                                                   game_over
);

   localparam int          GW      = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
   localparam int          CW      = $clog2(DEATH_TICKS + 1);
   localparam logic [CW-1:0] DC_LAST = CW'(DEATH_TICKS - 1);

   typedef enum logic [1:0] {
      PLAY    = 2'd0,
      DYING   = 2'd1,
      RESPAWN = 2'd2,
      OVER    = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [2:0]                lives_q, lives_d;
   logic                      hit_q, hit_d;
   logic [GW-1:0]             hit_ghost_q, hit_ghost_d;
   logic [CW-1:0]             death_cnt_q, death_cnt_d;
   logic                      prev_valid_q, prev_valid_d;
   logic [9:0]                prev_px_q;
   logic [8:0]                prev_py_q;
   logic [NUM_GHOSTS*10-1:0]  prev_gx_q;
   logic [NUM_GHOSTS*9-1:0]   prev_gy_q;

   logic [NUM_GHOSTS-1:0]     contact;
   logic [NUM_GHOSTS-1:0]     fatal;
   logic [GW-1:0]             fatal_idx;

`ifdef FRIGHT_EN
   logic                      eaten_q, eaten_d;
   logic [GW-1:0]             eaten_ghost_q, eaten_ghost_d;
   logic [NUM_GHOSTS-1:0]     eat;
   logic [GW-1:0]             eat_idx;
`endif

   // Contact is either sharing a tile now or having swapped tiles since the last tick.
   for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_contact
      logic same, swap;
      assign same = (ghost_x[gi*10 +: 10] == player_x) && (ghost_y[gi*9 +: 9] == player_y);
      assign swap = prev_valid_q
                    && (ghost_x[gi*10 +: 10] == prev_px_q) && (ghost_y[gi*9 +: 9] == prev_py_q)
                    && (player_x == prev_gx_q[gi*10 +: 10]) && (player_y == prev_gy_q[gi*9 +: 9]);
      assign contact[gi] = same | swap;
   end

`ifdef FRIGHT_EN
   assign fatal = contact & ~ghost_fright;
   assign eat   = contact & ghost_fright;
`else
   assign fatal = contact;
`endif

   always_comb begin
      fatal_idx = '0;
      for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
         if (fatal[i]) fatal_idx = GW'(i);
      end
   end

`ifdef FRIGHT_EN
   always_comb begin
      eat_idx = '0;
      for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
         if (eat[i]) eat_idx = GW'(i);
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      lives_d      = lives_q;
      hit_d        = 1'b0;
      hit_ghost_d  = hit_ghost_q;
      death_cnt_d  = death_cnt_q;
      prev_valid_d = prev_valid_q;
`ifdef FRIGHT_EN
      eaten_d       = 1'b0;
      eaten_ghost_d = eaten_ghost_q;
`endif
      case (state_q)
         PLAY: begin
            if (move_tick) begin
               prev_valid_d = 1'b1;
               if (|fatal) begin
                  hit_d       = 1'b1;
                  hit_ghost_d = fatal_idx;
                  lives_d     = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
                  death_cnt_d = '0;
                  state_d     = DYING;
               end
`ifdef FRIGHT_EN
               else if (|eat) begin
                  eaten_d       = 1'b1;
                  eaten_ghost_d = eat_idx;
               end
`endif
            end
         end
         DYING: begin
            if (move_tick) begin
               if (death_cnt_q == DC_LAST) begin
                  state_d = (lives_q == 3'd0) ? OVER : RESPAWN;
               end else begin
                  death_cnt_d = death_cnt_q + CW'(1);
               end
            end
         end
         RESPAWN: begin
            prev_valid_d = 1'b0;
            death_cnt_d  = '0;
            state_d      = PLAY;
         end
         default: begin
            state_d = OVER;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= PLAY;
         lives_q      <= 3'(LIVES_INIT);
         hit_q        <= 1'b0;
         hit_ghost_q  <= '0;
         death_cnt_q  <= '0;
         prev_valid_q <= 1'b0;
         prev_px_q    <= '0;
         prev_py_q    <= '0;
         prev_gx_q    <= '0;
         prev_gy_q    <= '0;
`ifdef FRIGHT_EN
         eaten_q       <= 1'b0;
         eaten_ghost_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         lives_q      <= lives_d;
         hit_q        <= hit_d;
         hit_ghost_q  <= hit_ghost_d;
         death_cnt_q  <= death_cnt_d;
         prev_valid_q <= prev_valid_d;
         if (state_q == PLAY && move_tick) begin
            prev_px_q <= player_x;
            prev_py_q <= player_y;
            prev_gx_q <= ghost_x;
            prev_gy_q <= ghost_y;
         end
`ifdef FRIGHT_EN
         eaten_q       <= eaten_d;
         eaten_ghost_q <= eaten_ghost_d;
`endif
      end
   end

   assign hit       = hit_q;
   assign hit_ghost = hit_ghost_q;
   assign lives     = lives_q;
   assign freeze    = (state_q != PLAY);
   assign respawn   = (state_q == RESPAWN);
   assign game_over = (state_q == OVER);
`ifdef FRIGHT_EN
   assign ghost_eaten = eaten_q;
   assign eaten_ghost = eaten_ghost_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ghost_collision_ctrl.sv
// ============================================================================
// tb_ghost_collision_ctrl : directed self-checking bench for ghost_collision_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ghost_collision_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        move_tick;
   logic [9:0]  player_x;
   logic [8:0]  player_y;
   logic [39:0] ghost_x;
   logic [35:0] ghost_y;

   logic        hit, freeze, respawn, game_over;
   logic [1:0]  hit_ghost;
   logic [2:0]  lives;
   logic        hit1, freeze1, respawn1, game_over1;
   logic [1:0]  hit_ghost1;
   logic [2:0]  lives1;
`ifdef FRIGHT_EN
   logic [3:0]  ghost_fright;
   logic        ghost_eaten, ghost_eaten1;
   logic [1:0]  eaten_ghost, eaten_ghost1;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ghost_collision_ctrl #(.NUM_GHOSTS(4), .LIVES_INIT(3), .DEATH_TICKS(8)) dut (
      .clk(clk), .reset(reset), .move_tick(move_tick),
      .player_x(player_x), .player_y(player_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
`ifdef FRIGHT_EN
      .ghost_fright(ghost_fright), .ghost_eaten(ghost_eaten), .eaten_ghost(eaten_ghost),
`endif
      .hit(hit), .hit_ghost(hit_ghost), .lives(lives), .freeze(freeze),
      .respawn(respawn), .game_over(game_over)
   );

   ghost_collision_ctrl #(.NUM_GHOSTS(4), .LIVES_INIT(1), .DEATH_TICKS(8)) dut1 (
      .clk(clk), .reset(reset), .move_tick(move_tick),
      .player_x(player_x), .player_y(player_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
`ifdef FRIGHT_EN
      .ghost_fright(ghost_fright), .ghost_eaten(ghost_eaten1), .eaten_ghost(eaten_ghost1),
`endif
      .hit(hit1), .hit_ghost(hit_ghost1), .lives(lives1), .freeze(freeze1),
      .respawn(respawn1), .game_over(game_over1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      move_tick = 1'b1;
      step();
      move_tick = 1'b0;
   endtask

   task automatic set_ghost(input int i, input logic [9:0] x, input logic [8:0] y);
      ghost_x[i*10 +: 10] = x;
      ghost_y[i*9 +: 9]   = y;
   endtask

   // Player at (300,200), ghosts spread along y=300: nothing in contact.
   task automatic place_far();
      player_x = 10'd300;
      player_y = 9'd200;
      for (int i = 0; i < 4; i++) set_ghost(i, 10'(480 + 40 * i), 9'd300);
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      move_tick = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      place_far();
      do_reset();
      n_cmp++; if (lives !== 3'd3)     begin n_err++; $display("FAIL reset_lives: got %0d want 3", lives); end
      n_cmp++; if (hit !== 1'b0)       begin n_err++; $display("FAIL reset_hit: got %0b want 0", hit); end
      n_cmp++; if (hit_ghost !== 2'd0) begin n_err++; $display("FAIL reset_hit_ghost: got %0d want 0", hit_ghost); end
      n_cmp++; if (freeze !== 1'b0)    begin n_err++; $display("FAIL reset_freeze: got %0b want 0", freeze); end
      n_cmp++; if (respawn !== 1'b0)   begin n_err++; $display("FAIL reset_respawn: got %0b want 0", respawn); end
      n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %0b want 0", game_over); end
      n_cmp++; if (lives1 !== 3'd1)    begin n_err++; $display("FAIL reset_lives1: got %0d want 1", lives1); end
   endtask

   task automatic test_same_tile();
      place_far();
      player_x = 10'd100; player_y = 9'd100;
      set_ghost(0, 10'd100, 9'd100);
      tick();
      n_cmp++; if (hit !== 1'b1)       begin n_err++; $display("FAIL same_hit: got %0b want 1", hit); end
      n_cmp++; if (hit_ghost !== 2'd0) begin n_err++; $display("FAIL same_hit_ghost: got %0d want 0", hit_ghost); end
      n_cmp++; if (lives !== 3'd2)     begin n_err++; $display("FAIL same_lives: got %0d want 2", lives); end
      n_cmp++; if (freeze !== 1'b1)    begin n_err++; $display("FAIL same_freeze: got %0b want 1", freeze); end
      step();
      n_cmp++; if (hit !== 1'b0)       begin n_err++; $display("FAIL same_hit_pulse: got %0b want 0", hit); end
   endtask

   // Entered in DYING; contact is held throughout to prove no extra hits occur.
   task automatic test_death_timer();
      for (int j = 0; j < 7; j++) begin
         tick();
         n_cmp++; if (freeze !== 1'b1 || respawn !== 1'b0 || hit !== 1'b0 || lives !== 3'd2) begin
            n_err++;
            $display("FAIL dying_tick%0d: freeze=%0b respawn=%0b hit=%0b lives=%0d want 1 0 0 2",
                     j + 1, freeze, respawn, hit, lives);
         end
         step();
      end
      place_far();
      tick();
      n_cmp++; if (respawn !== 1'b1)    begin n_err++; $display("FAIL respawn_pulse: got %0b want 1", respawn); end
      n_cmp++; if (game_over1 !== 1'b1) begin n_err++; $display("FAIL over1_game_over: got %0b want 1", game_over1); end
      n_cmp++; if (respawn1 !== 1'b0)   begin n_err++; $display("FAIL over1_respawn: got %0b want 0", respawn1); end
      step();
      n_cmp++; if (respawn !== 1'b0)    begin n_err++; $display("FAIL respawn_end: got %0b want 0", respawn); end
      n_cmp++; if (freeze !== 1'b0)     begin n_err++; $display("FAIL respawn_unfreeze: got %0b want 0", freeze); end
      n_cmp++; if (lives !== 3'd2)      begin n_err++; $display("FAIL respawn_lives: got %0d want 2", lives); end
   endtask

   // The LIVES_INIT=1 instance is in OVER here.
   task automatic test_game_over();
      place_far();
      set_ghost(2, 10'd300, 9'd200);
      tick();
      n_cmp++; if (hit1 !== 1'b0)       begin n_err++; $display("FAIL over1_no_hit: got %0b want 0", hit1); end
      n_cmp++; if (freeze1 !== 1'b1)    begin n_err++; $display("FAIL over1_freeze: got %0b want 1", freeze1); end
      n_cmp++; if (game_over1 !== 1'b1) begin n_err++; $display("FAIL over1_sticky: got %0b want 1", game_over1); end
      place_far();
      do_reset();
      n_cmp++; if (lives1 !== 3'd1 || game_over1 !== 1'b0 || freeze1 !== 1'b0) begin
         n_err++;
         $display("FAIL over1_reset: lives=%0d game_over=%0b freeze=%0b want 1 0 0", lives1, game_over1, freeze1);
      end
   endtask

   task automatic test_swap();
      place_far();
      do_reset();
      player_x = 10'd200; player_y = 9'd60;
      set_ghost(2, 10'd220, 9'd60);
      tick();
      n_cmp++; if (hit !== 1'b0) begin n_err++; $display("FAIL swap_tick1_hit: got %0b want 0", hit); end
      player_x = 10'd220;
      set_ghost(2, 10'd200, 9'd60);
      tick();
      n_cmp++; if (hit !== 1'b1)       begin n_err++; $display("FAIL swap_hit: got %0b want 1", hit); end
      n_cmp++; if (hit_ghost !== 2'd2) begin n_err++; $display("FAIL swap_hit_ghost: got %0d want 2", hit_ghost); end
      n_cmp++; if (lives !== 3'd2)     begin n_err++; $display("FAIL swap_lives: got %0d want 2", lives); end
   endtask

   task automatic test_first_tick_no_swap();
      place_far();
      do_reset();
      player_x = 10'd200; player_y = 9'd60;
      set_ghost(2, 10'd220, 9'd60);
      tick();
      do_reset();
      player_x = 10'd220;
      set_ghost(2, 10'd200, 9'd60);
      tick();
      n_cmp++; if (hit !== 1'b0 || freeze !== 1'b0) begin
         n_err++; $display("FAIL first_tick_swap: hit=%0b freeze=%0b want 0 0", hit, freeze);
      end
   endtask

   task automatic test_multi();
      place_far();
      do_reset();
      player_x = 10'd140; player_y = 9'd80;
      set_ghost(1, 10'd140, 9'd80);
      set_ghost(3, 10'd140, 9'd80);
      tick();
      n_cmp++; if (hit_ghost !== 2'd1) begin n_err++; $display("FAIL multi_hit_ghost: got %0d want 1", hit_ghost); end
      n_cmp++; if (lives !== 3'd2)     begin n_err++; $display("FAIL multi_lives: got %0d want 2", lives); end
      tick();
      n_cmp++; if (lives !== 3'd2)     begin n_err++; $display("FAIL multi_lives_once: got %0d want 2", lives); end
   endtask

   task automatic test_reset_mid_dying();
      place_far();
      do_reset();
      set_ghost(3, 10'd300, 9'd200);
      tick();
      tick();
      do_reset();
      n_cmp++; if (lives !== 3'd3 || freeze !== 1'b0 || hit !== 1'b0 || hit_ghost !== 2'd0) begin
         n_err++;
         $display("FAIL reset_mid_dying: lives=%0d freeze=%0b hit=%0b hit_ghost=%0d want 3 0 0 0",
                  lives, freeze, hit, hit_ghost);
      end
   endtask

   // Three deaths in a row on the LIVES_INIT=3 instance, ending in game over.
   task automatic test_back_to_back();
      place_far();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         place_far();
         set_ghost(k, 10'd300, 9'd200);
         tick();
         n_cmp++; if (hit !== 1'b1 || lives !== 3'(2 - k)) begin
            n_err++; $display("FAIL b2b_death%0d: hit=%0b lives=%0d want 1 %0d", k, hit, lives, 2 - k);
         end
         place_far();
         for (int j = 0; j < 8; j++) begin
            tick();
            if (j < 7) step();
         end
         if (k < 2) begin
            n_cmp++; if (respawn !== 1'b1) begin n_err++; $display("FAIL b2b_respawn%0d: got %0b want 1", k, respawn); end
            step();
         end else begin
            n_cmp++; if (game_over !== 1'b1 || respawn !== 1'b0) begin
               n_err++; $display("FAIL b2b_over: game_over=%0b respawn=%0b want 1 0", game_over, respawn);
            end
         end
      end
      set_ghost(0, 10'd300, 9'd200);
      tick();
      n_cmp++; if (hit !== 1'b0 || lives !== 3'd0) begin
         n_err++; $display("FAIL b2b_sat: hit=%0b lives=%0d want 0 0", hit, lives);
      end
   endtask

`ifdef FRIGHT_EN
   task automatic test_fright();
      place_far();
      ghost_fright = 4'b0001;
      do_reset();
      set_ghost(0, 10'd300, 9'd200);
      tick();
      n_cmp++; if (ghost_eaten !== 1'b1 || eaten_ghost !== 2'd0) begin
         n_err++; $display("FAIL fright_eat: eaten=%0b idx=%0d want 1 0", ghost_eaten, eaten_ghost);
      end
      n_cmp++; if (hit !== 1'b0 || lives !== 3'd3 || freeze !== 1'b0) begin
         n_err++; $display("FAIL fright_safe: hit=%0b lives=%0d freeze=%0b want 0 3 0", hit, lives, freeze);
      end
      set_ghost(1, 10'd300, 9'd200);
      tick();
      n_cmp++; if (hit !== 1'b1 || hit_ghost !== 2'd1 || ghost_eaten !== 1'b0) begin
         n_err++; $display("FAIL fright_death_wins: hit=%0b idx=%0d eaten=%0b want 1 1 0", hit, hit_ghost, ghost_eaten);
      end
      ghost_fright = 4'b0000;
   endtask
`endif

   initial begin
      reset     = 1'b0;
      move_tick = 1'b0;
      player_x  = '0;
      player_y  = '0;
      ghost_x   = '0;
      ghost_y   = '0;
`ifdef FRIGHT_EN
      ghost_fright = 4'b0000;
`endif
      test_reset();
      test_same_tile();
      test_death_timer();
      test_game_over();
      test_swap();
      test_first_tick_no_swap();
      test_multi();
      test_reset_mid_dying();
      test_back_to_back();
`ifdef FRIGHT_EN
      test_fright();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
